inbuff_pingpong: RTL and testbench

Double-buffered input activation buffer that sits directly upstream of the mask stage. It is filled from the DMA activation stream as 64-bit beats, each beat carrying 16 channels × 4 bit. It is read by the address generator's 9-bit tile address and returns 33 banks × 64 bit (2112 bit) per read, which drives the mask's din. Ping-pong operation lets the next tile load while the current tile is consumed.

---
 rtl/inbuff_pingpong.sv | 138 +++++++++++++
 tb/tb_inbuff_pingpong.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inbuff_pingpong.sv
// Ping-pong activation buffer: DMA beats fill one buffer bank-by-bank while the
// other buffer serves full NBANK-wide rows to the mask stage.
module inbuff_pingpong #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NBANK  = 33,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic                    done_tile,
  input  logic                    last_tile,
  output logic [NBANK*DATA_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    tile_ready,
  output logic                    layer_done,
  output logic                    err_ovf
);

  localparam int unsigned BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} buf_state_e;

  buf_state_e        state_q [2];
  buf_state_e        state_d [2];
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_full_q, wr_full_d;
  logic              err_ovf_q, err_ovf_d;

  logic [DATA_W-1:0]       mem [2][DEPTH][NBANK];
  logic [NBANK*DATA_W-1:0] rd_word;

  logic accept, release_tile, rd_fire, mem_we;

  assign s_tready     = (state_q[wr_sel_q] != StFull);
  assign tile_ready   = (state_q[rd_sel_q] == StFull);
  assign accept       = s_tvalid & s_tready;
  assign release_tile = done_tile & tile_ready;
  assign rd_fire      = rd_en & tile_ready;
  // Once the last slot is written, further beats are swallowed until tlast.
  assign mem_we       = accept & ~wr_full_q;
  assign err_ovf      = err_ovf_q;

  always_comb begin
    state_d   = state_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_full_d = wr_full_q;
    err_ovf_d = err_ovf_q;
    if (accept) begin
      if (s_tlast) begin
        state_d[wr_sel_q] = StFull;
        wr_sel_d          = ~wr_sel_q;
        wr_bank_d         = '0;
        wr_addr_d         = '0;
        wr_full_d         = 1'b0;
      end else begin
        state_d[wr_sel_q] = StFilling;
        if (!wr_full_q) begin
          if (wr_bank_q == BANK_W'(NBANK - 1)) begin
            wr_bank_d = '0;
            if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
              wr_full_d = 1'b1;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
          end else begin
            wr_bank_d = wr_bank_q + BANK_W'(1);
          end
        end
      end
      if (wr_full_q) begin
        err_ovf_d = 1'b1;
      end
    end
    // The writer never targets a FULL buffer, so this cannot collide with the write update.
    if (release_tile) begin
      state_d[rd_sel_q] = StEmpty;
      rd_sel_d          = ~rd_sel_q;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NBANK; b++) begin
      rd_word[b*DATA_W +: DATA_W] = mem[rd_sel_q][rd_addr[IDX_W-1:0]][BANK_W'(b)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0] <= StEmpty;
      state_q[1] <= StEmpty;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      wr_full_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      wr_full_q  <= wr_full_d;
      err_ovf_q  <= err_ovf_d;
      rd_valid   <= rd_fire;
      layer_done <= release_tile & last_tile;
      if (rd_fire) begin
        rd_data <= rd_word;
      end
    end
  end

  // Storage is never cleared; reset only blocks writes.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && mem_we) begin
      mem[wr_sel_q][wr_addr_q[IDX_W-1:0]][wr_bank_q] <= s_tdata;
    end
  end

endmodule

// File: tb/tb_inbuff_pingpong.sv
// Scoreboard bench for inbuff_pingpong with a shallow buffer so the overflow
// boundary is reachable in a handful of beats.
module tb_inbuff_pingpong;

  localparam int DW  = 64;
  localparam int NB  = 33;
  localparam int AW  = 9;
  localparam int DEP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW-1:0]     s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic              done_tile = 1'b0;
  logic              last_tile = 1'b0;
  logic [NB*DW-1:0]  rd_data;
  logic              rd_valid;
  logic              tile_ready;
  logic              layer_done;
  logic              err_ovf;

  inbuff_pingpong #(
    .DATA_W(DW),
    .NBANK (NB),
    .ADDR_W(AW),
    .DEPTH (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .done_tile (done_tile),
    .last_tile (last_tile),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .tile_ready(tile_ready),
    .layer_done(layer_done),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [NB*DW-1:0] exp_q[$];
  logic [NB*DW-1:0] last_exp = '0;
  logic [NB*DW-1:0] mon_exp;
  bit               mon_shown;

  function automatic logic [DW-1:0] beat(input int base, input int k);
    logic [7:0] v;
    v = 8'(base + k);
    return {8{v}};
  endfunction

  // Row a of a tile holds beats a*NB .. a*NB+NB-1, bank b at bits [b*DW +: DW].
  function automatic logic [NB*DW-1:0] row(input int base, input int addr);
    logic [NB*DW-1:0] r;
    logic [7:0]       v;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      v = 8'(base + addr * NB + b);
      r[b*DW +: DW] = {8{v}};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read");
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_errors++;
          mon_shown = 1'b0;
          for (int b = 0; b < NB; b++) begin
            if (!mon_shown && rd_data[b*DW +: DW] !== mon_exp[b*DW +: DW]) begin
              $display("FAIL rd_data bank %0d: got %h expected %h", b, rd_data[b*DW +: DW],
                       mon_exp[b*DW +: DW]);
              mon_shown = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int n;
    n        = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_tready) begin
      n_checks++;
      n_errors++;
      $display("FAIL s_tready_timeout: got s_tready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_tile(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      send_beat(beat(base, k), (k == n - 1));
    end
  endtask

  task automatic rd(input int addr, input logic [NB*DW-1:0] e);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_done(input logic last);
    done_tile = 1'b1;
    last_tile = last;
    @(posedge clk);
    #1;
    done_tile = 1'b0;
    last_tile = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    chk("rst_s_tready", s_tready, 1);
    chk("rst_tile_ready", tile_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data_zero", (rd_data == '0), 1);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_layer_done", layer_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single 99-beat tile into buffer 0
    for (int k = 0; k < 98; k++) send_beat(beat(0, k), 1'b0);
    chk("t1_not_ready_before_tlast", tile_ready, 0);
    send_beat(beat(0, 98), 1'b1);
    chk("t1_tile_ready", tile_ready, 1);
    rd(1, row(0, 1));
    rd(0, row(0, 0));
    rd(2, row(0, 2));
    pulse_done(1'b0);
    chk("t1_released", tile_ready, 0);
    chk("t1_no_layer_done", layer_done, 0);

    // Ping-pong: buffer 1 then buffer 0, both full
    send_tile(100, 66);
    send_tile(200, 66);
    chk("t2_s_tready_low", s_tready, 0);
    chk("t2_tile_ready", tile_ready, 1);
    rd(0, row(100, 0));
    rd(1, row(100, 1));
    s_tvalid = 1'b1;
    s_tdata  = beat(300, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t2_stall", s_tready, 0);
    end
    s_tvalid = 1'b0;
    pulse_done(1'b0);
    chk("t2_s_tready_rise", s_tready, 1);
    chk("t2_next_tile_ready", tile_ready, 1);
    send_beat(beat(300, 0), 1'b0);
    rd(0, row(200, 0));

    // tlast into buffer 1 coincides with release of buffer 0
    for (int k = 1; k < 65; k++) send_beat(beat(300, k), 1'b0);
    done_tile = 1'b1;
    send_beat(beat(300, 65), 1'b1);
    done_tile = 1'b0;
    chk("t3_tile_ready", tile_ready, 1);
    chk("t3_s_tready", s_tready, 1);
    rd(0, row(300, 0));
    rd(1, row(300, 1));

    // layer_done pulse, then ignored done_tile and read with no tile
    pulse_done(1'b1);
    chk("t4_layer_done_pulse", layer_done, 1);
    chk("t4_empty_after_last", tile_ready, 0);
    @(posedge clk);
    #1;
    chk("t4_layer_done_one_cycle", layer_done, 0);
    pulse_done(1'b1);
    chk("t4_ignored_no_layer_done", layer_done, 0);
    chk("t4_ignored_tile_ready", tile_ready, 0);
    chk("t4_ignored_s_tready", s_tready, 1);
    rd_en   = 1'b1;
    rd_addr = '0;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("t4_rd_no_tile_valid", rd_valid, 0);
    chk("t4_rd_no_tile_hold", (rd_data == last_exp), 1);

    // Overflow: 133 beats into a 4x33 buffer
    for (int k = 0; k < 132; k++) send_beat(beat(0, k), 1'b0);
    chk("t5_no_ovf_at_capacity", err_ovf, 0);
    send_beat(beat(0, 132), 1'b1);
    chk("t5_err_ovf_set", err_ovf, 1);
    chk("t5_tile_ready", tile_ready, 1);
    rd(0, row(0, 0));
    rd(1, row(0, 1));
    rd(2, row(0, 2));
    done_tile = 1'b1;
    rd(3, row(0, 3));
    done_tile = 1'b0;
    chk("t5_released_with_read", tile_ready, 0);
    chk("t5_err_ovf_sticky", err_ovf, 1);

    // Reset mid-fill while a read result is on the output
    send_tile(50, 66);
    for (int k = 0; k < 40; k++) send_beat(beat(150, k), 1'b0);
    rd(0, row(50, 0));
    s_tvalid = 1'b1;
    s_tdata  = beat(150, 40);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_rd_valid", rd_valid, 0);
    chk("t6_rst_tile_ready", tile_ready, 0);
    chk("t6_rst_rd_data", (rd_data == '0), 1);
    chk("t6_rst_err_ovf", err_ovf, 0);
    repeat (3) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    rst      = 1'b1;
    chk("t6_post_s_tready", s_tready, 1);
    chk("t6_post_tile_ready", tile_ready, 0);
    send_tile(7, 33);
    chk("t6_fresh_tile_ready", tile_ready, 1);
    rd(0, row(7, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
